// File: rtl/branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl
//
// Purpose: keeps the fetch address in order around branches and jumps. Fetch
// runs in RUN. When decode issues a branch or jump, one stall cycle (RESOLVE)
// waits for the branch unit's registered decision. A taken result loads pc
// from br_target, pulses redirect, and kills younger instructions for
// FLUSH_CYCLES cycles (FLUSH) before fetch resumes.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   dec_valid    decode presents an instruction this cycle
//   dec_b/dec_j  conditional-branch / jump flags of that instruction
//   br_taken     registered branch decision, sampled on the RESOLVE exit edge
//   br_target    registered branch target, sampled with br_taken
//   fetch_ready  fetch accepts pc this cycle
//   pc           current fetch byte address
//   pc_valid     pc is a legal fetch request (RUN only)
//   stall        decode must hold (RESOLVE and FLUSH)
//   flush        kill fetch/decode instructions (FLUSH)
//   redirect     one-cycle pulse: pc was just loaded from br_target
//   misalign     sticky: some taken target had nonzero low two bits
//   taken_cnt    saturating count of taken branches and jumps
// -----------------------------------------------------------------------------
module branch_redirect_ctrl #(
  parameter logic [9:0] RESET_PC     = 10'h000,
  parameter int         FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic        dec_b,
  input  logic        dec_j,
  input  logic        br_taken,
  input  logic [9:0]  br_target,
  input  logic        fetch_ready,
  output logic [9:0]  pc,
  output logic        pc_valid,
  output logic        stall,
  output logic        flush,
  output logic        redirect,
  output logic        misalign,
  output logic [15:0] taken_cnt
);

  typedef enum logic [1:0] {RUN, RESOLVE, FLUSH} state_t;

  // The counter is loaded with the number of FLUSH cycles still to follow the
  // first one, so FLUSH exits on the cycle the counter reads zero.
  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [9:0]  pc_q, pc_d;
  logic        redirect_q, redirect_d;
  logic        misalign_q, misalign_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  fcnt_q, fcnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= 16'd0;
      fcnt_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
      fcnt_q     <= fcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    fcnt_d     = fcnt_q;
    case (state_q)
      RUN: begin
        // A branch/jump freezes pc even if fetch accepts it this edge.
        if (dec_valid && (dec_b || dec_j)) begin
          state_d = RESOLVE;
        end else if (fetch_ready) begin
          pc_d = pc_q + 10'd4;  // wraps modulo 1024
        end
      end
      RESOLVE: begin
        if (br_taken) begin
          state_d    = FLUSH;
          pc_d       = br_target;
          redirect_d = 1'b1;
          cnt_d      = sat_inc(cnt_q);
          fcnt_d     = FLUSH_LAST;
          if (br_target[1:0] != 2'b00) misalign_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (fcnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs come straight from registers or decode of the state register.
  assign pc        = pc_q;
  assign pc_valid  = (state_q == RUN);
  assign stall     = (state_q != RUN);
  assign flush     = (state_q == FLUSH);
  assign redirect  = redirect_q;
  assign misalign  = misalign_q;
  assign taken_cnt = cnt_q;

endmodule
